// File: rtl/shiftrows_iter.sv
// shiftrows_iter
// Forward AES ShiftRows for the encryption datapath, wrapped in a small
// start/ack handshake so the round controller can hand it a state and pick
// up the result whenever it is ready.
//
// Byte b[j] lives at state[127-8j -: 8] (column-major), so row r / column c
// is b[4c+r]. ShiftRows rotates row r left by r columns.
//
// ITERATIVE = 1 : the state is latched, then rows are rotated one column per
//                 cycle over three SHIFT cycles (rows > step move each cycle).
// ITERATIVE = 0 : the full ShiftRows is applied on the accept edge itself.
//
// Ports
//   clk        in   1    system clock, rising edge
//   rst_n      in   1    synchronous reset, active-low
//   start      in   1    request, taken in IDLE or together with ack in DONE
//   state_in   in   128  input state, sampled on the accept edge
//   ack        in   1    consumer has taken state_out (DONE only)
//   busy       out  1    high in SHIFT and DONE
//   state_out  out  128  registered ShiftRows result, valid while done_sr=1
//   done_sr    out  1    result valid, held until ack

module shiftrows_iter #(
    parameter int ITERATIVE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [127:0] state_in,
    input  logic         ack,
    output logic         busy,
    output logic [127:0] state_out,
    output logic         done_sr
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } srState_t;

    srState_t     r_state;
    srState_t     w_nextState;
    logic [127:0] r_work;
    logic [127:0] w_nextWork;
    logic [1:0]   r_step;
    logic [1:0]   w_nextStep;
    logic [127:0] r_stateOut;
    logic [127:0] w_nextStateOut;
    logic [127:0] w_rotated;
    logic [127:0] w_fullShift;

    // One rotation pass: every row strictly above minRow moves left by one
    // column; rows at or below minRow are copied unchanged.
    function automatic logic [127:0] rotateRows(input logic [127:0] s,
                                                input logic [1:0]   minRow);
        logic [127:0] res;
        res = s;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (r > int'(minRow)) begin
                    res[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+1)%4)+r) -: 8];
                end
            end
        end
        return res;
    endfunction

    // Three passes with growing minRow give row r exactly r rotations,
    // which is the complete ShiftRows; the iterative path walks the same
    // sequence one pass per cycle.
    assign w_rotated   = rotateRows(r_work, r_step);
    assign w_fullShift = rotateRows(rotateRows(rotateRows(state_in, 2'd0), 2'd1), 2'd2);

    // Next-state logic. Accepting a request is shared between IDLE and the
    // back-to-back case in DONE, so both branches use identical updates.
    // The SHIFT state deliberately ignores start and ack.
    always_comb begin
        w_nextState    = r_state;
        w_nextWork     = r_work;
        w_nextStep     = r_step;
        w_nextStateOut = r_stateOut;
        unique case (r_state)
            IDLE: begin
                if (start) begin
                    if (ITERATIVE != 0) begin
                        w_nextWork  = state_in;
                        w_nextStep  = 2'd0;
                        w_nextState = SHIFT;
                    end else begin
                        w_nextStateOut = w_fullShift;
                        w_nextState    = DONE;
                    end
                end
            end
            SHIFT: begin
                w_nextWork = w_rotated;
                if (r_step == 2'd2) begin
                    w_nextStateOut = w_rotated;
                    w_nextStep     = 2'd0;
                    w_nextState    = DONE;
                end else begin
                    w_nextStep = r_step + 2'd1;
                end
            end
            DONE: begin
                if (ack) begin
                    if (start) begin
                        if (ITERATIVE != 0) begin
                            w_nextWork  = state_in;
                            w_nextStep  = 2'd0;
                            w_nextState = SHIFT;
                        end else begin
                            w_nextStateOut = w_fullShift;
                            w_nextState    = DONE;
                        end
                    end else begin
                        w_nextState = IDLE;
                    end
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // State and datapath registers. Reset wins over any in-flight
    // operation and clears the result so no partial value is exposed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_work     <= '0;
            r_step     <= 2'd0;
            r_stateOut <= '0;
        end else begin
            r_state    <= w_nextState;
            r_work     <= w_nextWork;
            r_step     <= w_nextStep;
            r_stateOut <= w_nextStateOut;
        end
    end

    assign busy      = (r_state != IDLE);
    assign done_sr   = (r_state == DONE);
    assign state_out = r_stateOut;

endmodule

// File: tb/tb_shiftrows_iter.sv
// tb_shiftrows_iter
// Directed and random checks of shiftrows_iter in both build modes.
// Instance 1 is ITERATIVE=1, instance 0 is ITERATIVE=0; each has its own
// start/ack/state_in so the two can be exercised independently.

module tb_shiftrows_iter;

    logic         clk;
    logic         rst_n;
    logic [1:0]   startV;
    logic [1:0]   ackV;
    logic [1:0]   busyV;
    logic [1:0]   doneV;
    logic [127:0] inV  [2];
    logic [127:0] outV [2];

    int total;
    int bad;

    // Output byte k of ShiftRows comes from input byte srIdx[k].
    localparam int srIdx [16] = '{0, 5, 10, 15, 4, 9, 14, 3, 8, 13, 2, 7, 12, 1, 6, 11};

    shiftrows_iter #(.ITERATIVE(1)) dutIter (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (startV[1]),
        .state_in  (inV[1]),
        .ack       (ackV[1]),
        .busy      (busyV[1]),
        .state_out (outV[1]),
        .done_sr   (doneV[1])
    );

    shiftrows_iter #(.ITERATIVE(0)) dutFull (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (startV[0]),
        .state_in  (inV[0]),
        .ack       (ackV[0]),
        .busy      (busyV[0]),
        .state_out (outV[0]),
        .done_sr   (doneV[0])
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference ShiftRows built from the byte-index table.
    function automatic logic [127:0] refShift(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*k -: 8] = s[127-8*srIdx[k] -: 8];
        return r;
    endfunction

    // Reference inverse: scatter each output byte back to its source slot.
    function automatic logic [127:0] refInvShift(input logic [127:0] s);
        logic [127:0] r;
        for (int k = 0; k < 16; k++) r[127-8*srIdx[k] -: 8] = s[127-8*k -: 8];
        return r;
    endfunction

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [127:0] got, input logic [127:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Wait (bounded) for done, then check latency in edges after the
    // accept edge and the result value.
    task automatic waitDone(input int sel, input string tag, input int expLat, input logic [127:0] expOut);
        int lat;
        lat = 0;
        while (!doneV[sel] && lat < 10) begin
            tick();
            lat++;
        end
        if (!doneV[sel]) lat = 99;
        checkOutput({tag, "_lat"}, 128'(lat), 128'(expLat));
        checkOutput({tag, "_out"}, outV[sel], expOut);
    endtask

    // Issue one request from IDLE, scramble state_in right after the
    // accept edge, and check the completed result.
    task automatic applyStimulus(input int sel, input logic [127:0] data, input string tag);
        startV[sel] = 1'b1;
        inV[sel]    = data;
        tick();
        startV[sel] = 1'b0;
        inV[sel]    = ~data;
        waitDone(sel, tag, (sel == 1) ? 3 : 0, refShift(data));
    endtask

    // Acknowledge with start low; unit must return to IDLE.
    task automatic ackOp(input int sel, input string tag);
        ackV[sel] = 1'b1;
        tick();
        ackV[sel] = 1'b0;
        checkOutput({tag, "_ackdone"}, 128'(doneV[sel]), 128'(0));
        checkOutput({tag, "_ackbusy"}, 128'(busyV[sel]), 128'(0));
    endtask

    localparam logic [127:0] VEC_A = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] EXP_A = 128'h00050a0f04090e03080d02070c01060b;
    localparam logic [127:0] VEC_B = 128'hd42711aee0bf98f1b8b45de51e415230;
    localparam logic [127:0] EXP_B = 128'hd4bf5d30e0b452aeb84111f11e2798e5;

    // Main sequence.
    initial begin
        logic [127:0] rnd;
        total  = 0;
        bad    = 0;
        rst_n  = 1'b0;
        startV = 2'b00;
        ackV   = 2'b00;
        inV[0] = '0;
        inV[1] = '0;
        tick();
        tick();
        for (int s = 0; s < 2; s++) begin
            checkOutput($sformatf("rst_busy%0d", s), 128'(busyV[s]), 128'(0));
            checkOutput($sformatf("rst_done%0d", s), 128'(doneV[s]), 128'(0));
            checkOutput($sformatf("rst_out%0d", s), outV[s], 128'(0));
        end
        rst_n = 1'b1;
        tick();

        // Known-answer vector, both modes; hand-derived result as well.
        applyStimulus(1, VEC_A, "t1_iter");
        checkOutput("t1_kat_iter", outV[1], EXP_A);
        ackOp(1, "t1_iter");
        applyStimulus(0, VEC_A, "t1_full");
        checkOutput("t1_kat_full", outV[0], EXP_A);
        ackOp(0, "t1_full");

        // FIPS-197 round-1 value, held five cycles without ack.
        applyStimulus(1, VEC_B, "t2");
        checkOutput("t2_kat", outV[1], EXP_B);
        repeat (5) tick();
        checkOutput("t2_hold_done", 128'(doneV[1]), 128'(1));
        checkOutput("t2_hold_out", outV[1], EXP_B);
        ackOp(1, "t2");
        checkOutput("t2_keep_out", outV[1], EXP_B);

        // Back-to-back: start together with ack while in DONE.
        applyStimulus(1, VEC_A, "t3a_iter");
        startV[1] = 1'b1;
        ackV[1]   = 1'b1;
        inV[1]    = VEC_B;
        tick();
        startV[1] = 1'b0;
        ackV[1]   = 1'b0;
        inV[1]    = VEC_A;
        checkOutput("t3_iter_drop", 128'(doneV[1]), 128'(0));
        checkOutput("t3_iter_busy", 128'(busyV[1]), 128'(1));
        waitDone(1, "t3b_iter", 3, EXP_B);
        ackOp(1, "t3_iter");
        applyStimulus(0, VEC_A, "t3a_full");
        startV[0] = 1'b1;
        ackV[0]   = 1'b1;
        inV[0]    = VEC_B;
        tick();
        startV[0] = 1'b0;
        ackV[0]   = 1'b0;
        waitDone(0, "t3b_full", 0, EXP_B);
        ackOp(0, "t3_full");

        // Reset while the iterative unit is at step 1.
        startV[1] = 1'b1;
        inV[1]    = VEC_A;
        tick();
        startV[1] = 1'b0;
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checkOutput("t4_busy", 128'(busyV[1]), 128'(0));
        checkOutput("t4_done", 128'(doneV[1]), 128'(0));
        checkOutput("t4_out", outV[1], 128'(0));
        applyStimulus(1, VEC_B, "t4_after");
        ackOp(1, "t4");

        // Start held high through SHIFT and unacknowledged DONE with a
        // different state_in; only the accepted input may show up.
        startV[1] = 1'b1;
        inV[1]    = VEC_A;
        tick();
        inV[1]    = VEC_B;
        waitDone(1, "t5", 3, EXP_A);
        repeat (3) tick();
        checkOutput("t5_hold_done", 128'(doneV[1]), 128'(1));
        checkOutput("t5_hold_out", outV[1], EXP_A);
        startV[1] = 1'b0;
        ackOp(1, "t5");

        // Random states in both modes, checked against the reference and
        // by round-tripping through the inverse permutation.
        for (int s = 0; s < 2; s++) begin
            for (int n = 0; n < 100; n++) begin
                rnd = {$urandom, $urandom, $urandom, $urandom};
                applyStimulus(s, rnd, $sformatf("t6_%0d_%0d", s, n));
                checkOutput($sformatf("t6_inv_%0d_%0d", s, n), refInvShift(outV[s]), rnd);
                ackOp(s, $sformatf("t6_%0d_%0d", s, n));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
